// File: rtl/switch_debouncer.sv
`timescale 1ns/1ps
// Purpose: per-channel synchroniser + counter stability filter + rise/fall pulses for raw slide switches.
// Latency: a step settled before edge k shows on oSwitch at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
// Backpressure: none; inputs are free-running levels and outputs are always-valid registered levels/pulses.
module switch_debouncer #(
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic [NUM_SW-1:0] iSwitch,
   output logic [NUM_SW-1:0] oSwitch,
   output logic [NUM_SW-1:0] oRise,
   output logic [NUM_SW-1:0] oFall
);

   // Wide enough to hold DEBOUNCE_CYCLES; the counter is cleared before it could ever reach it.
   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0][SYNC_STAGES-1:0] syncChain;
   logic [NUM_SW-1:0]                  syncLvl;
   logic [NUM_SW-1:0][CNT_W-1:0]       stableCnt;

   // Shift each raw switch level through its own synchroniser chain; bit 0 is the metastable capture flop.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         syncChain <= '0;
      end else begin
         for (int i = 0; i < NUM_SW; i++) begin
            if (SYNC_STAGES > 1) begin
               syncChain[i] <= {syncChain[i][SYNC_STAGES-2:0], iSwitch[i]};
            end else begin
               syncChain[i] <= SYNC_STAGES'(iSwitch[i]);
            end
         end
      end
   end

   // The last flop of each chain is the only view of the switch the filter is allowed to see.
   always_comb begin
      syncLvl = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         syncLvl[i] = syncChain[i][SYNC_STAGES-1];
      end
   end

   // Accept a new level only after it has disagreed with the current output for DEBOUNCE_CYCLES
   // consecutive edges; any agreement in between restarts the count. Pulses ride with the update.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stableCnt <= '0;
         oSwitch   <= '0;
         oRise     <= '0;
         oFall     <= '0;
      end else begin
         oRise <= '0;
         oFall <= '0;
         for (int i = 0; i < NUM_SW; i++) begin
            if (syncLvl[i] == oSwitch[i]) begin
               stableCnt[i] <= '0;
            end else if (stableCnt[i] == CNT_LAST) begin
               stableCnt[i] <= '0;
               oSwitch[i]   <= syncLvl[i];
               oRise[i]     <= syncLvl[i];
               oFall[i]     <= ~syncLvl[i];
            end else begin
               stableCnt[i] <= stableCnt[i] + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
`timescale 1ns/1ps
module tb_switch_debouncer;

   localparam int NSW = 4;
   localparam int DEB = 8;
   localparam int SYN = 2;
   localparam int HL  = SYN + DEB;

   logic           iClk = 1'b0;
   logic           iRst_n;
   logic [NSW-1:0] iSwitch;
   logic [NSW-1:0] oSwitch;
   logic [NSW-1:0] oRise;
   logic [NSW-1:0] oFall;

   switch_debouncer #(
      .NUM_SW         (NSW),
      .DEBOUNCE_CYCLES(DEB),
      .SYNC_STAGES    (SYN)
   ) dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iSwitch(iSwitch),
      .oSwitch(oSwitch),
      .oRise  (oRise),
      .oFall  (oFall)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int errors = 0;

   // Reference model: per channel, a history of the raw level seen at each edge. The filter at edge n
   // looks at the raw sample from SYN edges earlier; the output flips when the last DEB such samples
   // all differ from the current output.
   logic [NSW-1:0] mOut, mRise, mFall;
   logic [HL-1:0]  hist [NSW];

   int tcount;
   int nRise [NSW];
   int nFall [NSW];
   int firstRise [NSW];
   int firstFall [NSW];

   typedef struct {
      logic [NSW-1:0] sw;
      logic [NSW-1:0] expSw;
      logic [NSW-1:0] expRise;
      logic [NSW-1:0] expFall;
   } vec_t;
   vec_t vecs [12];

   int gw [3] = '{5, 7, 8};
   int ge [3] = '{0, 0, 1};
   logic bounceSeq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic check(input string name, input logic [NSW-1:0] act, input logic [NSW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mOut  = '0;
      mRise = '0;
      mFall = '0;
      for (int i = 0; i < NSW; i++) hist[i] = '0;
   endtask

   task automatic modelEdge(input logic [NSW-1:0] sw);
      logic [DEB-1:0] win;
      mRise = '0;
      mFall = '0;
      for (int i = 0; i < NSW; i++) begin
         hist[i] = {hist[i][HL-2:0], sw[i]};
         win = hist[i][HL-1:SYN];
         if (win == {DEB{~mOut[i]}}) begin
            mOut[i] = ~mOut[i];
            if (mOut[i]) mRise[i] = 1'b1;
            else         mFall[i] = 1'b1;
         end
      end
   endtask

   task automatic clearStats();
      tcount = 0;
      for (int i = 0; i < NSW; i++) begin
         nRise[i] = 0;
         nFall[i] = 0;
         firstRise[i] = -1;
         firstFall[i] = -1;
      end
   endtask

   // One clock: advance the model on the edge, compare #1 later, and log pulse positions.
   task automatic tick();
      @(posedge iClk);
      if (iRst_n) modelEdge(iSwitch);
      #1;
      tcount++;
      check("oSwitch vs model", oSwitch, mOut);
      check("oRise vs model", oRise, mRise);
      check("oFall vs model", oFall, mFall);
      for (int i = 0; i < NSW; i++) begin
         if (oRise[i]) begin
            nRise[i]++;
            if (firstRise[i] < 0) firstRise[i] = tcount;
         end
         if (oFall[i]) begin
            nFall[i]++;
            if (firstFall[i] < 0) firstFall[i] = tcount;
         end
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      // Power-up with all switches high: the first post-release edge samples the input, so the
      // accepted level appears nine edges after it (edge 10 counting that first edge as 1).
      for (int j = 0; j < 12; j++) begin
         vecs[j].sw      = 4'hF;
         vecs[j].expSw   = (j + 1 >= 10) ? 4'hF : 4'h0;
         vecs[j].expRise = (j + 1 == 10) ? 4'hF : 4'h0;
         vecs[j].expFall = 4'h0;
      end

      iRst_n  = 1'b0;
      iSwitch = 4'hF;
      modelReset();
      clearStats();
      ticks(3);
      check("reset oSwitch", oSwitch, 4'h0);
      check("reset oRise", oRise, 4'h0);
      iRst_n = 1'b1;

      clearStats();
      for (int j = 0; j < 12; j++) begin
         iSwitch = vecs[j].sw;
         tick();
         check("table oSwitch", oSwitch, vecs[j].expSw);
         check("table oRise", oRise, vecs[j].expRise);
         check("table oFall", oFall, vecs[j].expFall);
      end
      iSwitch = 4'h0;
      ticks(12);

      // Clean step on channel 0, rising then falling.
      clearStats();
      iSwitch[0] = 1'b1;
      ticks(12);
      checkInt("step rise edge", firstRise[0], 10);
      checkInt("step rise count", nRise[0], 1);
      checkInt("step rise no fall", nFall[0], 0);
      check("step rise others", oSwitch, 4'b0001);
      clearStats();
      iSwitch[0] = 1'b0;
      ticks(12);
      checkInt("step fall edge", firstFall[0], 10);
      checkInt("step fall count", nFall[0], 1);
      checkInt("step fall no rise", nRise[0], 0);
      check("step fall others", oSwitch, 4'b0000);

      // Glitches on channel 1 of 5, 7 and 8 cycles.
      for (int g = 0; g < 3; g++) begin
         clearStats();
         iSwitch[1] = 1'b1;
         ticks(gw[g]);
         iSwitch[1] = 1'b0;
         ticks(14);
         checkInt("glitch rise count", nRise[1], ge[g]);
         checkInt("glitch fall count", nFall[1], ge[g]);
         check("glitch end oSwitch", oSwitch, 4'b0000);
      end

      // Bounce on channel 2: final hold begins with the fifth sample, visible on sync after edge 6.
      clearStats();
      for (int b = 0; b < 5; b++) begin
         iSwitch[2] = bounceSeq[b];
         tick();
      end
      ticks(15);
      checkInt("bounce rise edge", firstRise[2], 14);
      checkInt("bounce rise count", nRise[2], 1);
      checkInt("bounce fall count", nFall[2], 0);
      iSwitch[2] = 1'b0;
      ticks(12);

      // Async reset while channel 3 has counted to 5.
      iSwitch[0] = 1'b1;
      ticks(12);
      clearStats();
      iSwitch[3] = 1'b1;
      ticks(7);
      check("pre-reset oSwitch", oSwitch, 4'b0001);
      iRst_n = 1'b0;
      #0.5;
      check("async reset oSwitch", oSwitch, 4'b0000);
      check("async reset oRise", oRise, 4'b0000);
      check("async reset oFall", oFall, 4'b0000);
      modelReset();
      #0.5;
      iRst_n = 1'b1;
      clearStats();
      ticks(12);
      checkInt("requalify ch3 edge", firstRise[3], 10);
      checkInt("requalify ch0 edge", firstRise[0], 10);
      checkInt("requalify ch3 count", nRise[3], 1);

      // Simultaneous rise on channel 0 and fall on channel 1.
      iSwitch = 4'b1010;
      ticks(12);
      iSwitch = 4'b1001;
      ticks(9);
      tick();
      check("simul oRise", oRise, 4'b0001);
      check("simul oFall", oFall, 4'b0010);
      ticks(4);

      // Random per-channel toggling: runs average about ten cycles, so both short glitches and
      // accepted changes occur.
      repeat (3000) begin
         for (int i = 0; i < NSW; i++) begin
            if ($urandom_range(0, 9) == 0) iSwitch[i] = ~iSwitch[i];
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
